// File: rtl/mem_bus_master.sv
// Memory-stage bus initiator: one load/store at a time over a req/ack word bus.
// Checks alignment, lane-replicates store data, extends load data and stalls
// the pipeline until the access completes, fails alignment or times out.
//
// state  | meaning
// IDLE   | waiting for mem_valid; latches the access when it arrives
// REQ    | bus_req held with latched addr/be/wdata/we until bus_ack or timeout
// DONE   | one-cycle done pulse with rdata and error flags
module mem_bus_master #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  mem_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_align,
    output logic        err_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_HU = 3'b010;
    localparam logic [2:0] T_B  = 3'b011;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        off_q, off_d;
    logic              done_q, done_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_align_q, err_align_d;
    logic              err_timeout_q, err_timeout_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;

    function automatic logic [3:0] calc_be(input logic [2:0] t, input logic [1:0] off);
        case (t)
            T_H, T_HU: calc_be = off[1] ? 4'b1100 : 4'b0011;
            T_B, T_BU: calc_be = 4'b0001 << off;
            default:   calc_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] t, input logic [31:0] w);
        case (t)
            T_H, T_HU: calc_wdata = {w[15:0], w[15:0]};
            T_B, T_BU: calc_wdata = {4{w[7:0]}};
            default:   calc_wdata = w;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? w[31:16] : w[15:0];
        b = w[{off, 3'b000} +: 8];
        case (t)
            T_H:     extract = {{16{h[15]}}, h};
            T_HU:    extract = {16'h0000, h};
            T_B:     extract = {{24{b[7]}}, b};
            T_BU:    extract = {24'h000000, b};
            default: extract = w;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
        case (t)
            T_H, T_HU: misaligned = off[0];
            T_B, T_BU: misaligned = 1'b0;
            default:   misaligned = (off != 2'b00);
        endcase
    endfunction

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        type_d        = type_q;
        off_d         = off_q;
        done_d        = 1'b0;
        rdata_d       = rdata_q;
        err_align_d   = 1'b0;
        err_timeout_d = 1'b0;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    we_d   = mem_we;
                    type_d = mem_type;
                    off_d  = mem_addr[1:0];
                    cnt_d  = '0;
                    if (misaligned(mem_type, mem_addr[1:0])) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        err_align_d = 1'b1;
                        rdata_d     = '0;
                    end else begin
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_we;
                        bus_addr_d  = {mem_addr[31:2], 2'b00};
                        bus_be_d    = calc_be(mem_type, mem_addr[1:0]);
                        bus_wdata_d = calc_wdata(mem_type, mem_wdata);
                    end
                end
            end
            S_REQ: begin
                if (bus_ack || cnt_q == CNT_LAST) begin
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                    err_timeout_d = !bus_ack;
                    rdata_d       = (bus_ack && !we_q) ? extract(type_q, off_q, bus_rdata) : '0;
                    bus_req_d     = 1'b0;
                    bus_we_d      = 1'b0;
                    bus_addr_d    = '0;
                    bus_be_d      = '0;
                    bus_wdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register all state and outputs; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            type_q        <= '0;
            off_q         <= '0;
            done_q        <= 1'b0;
            rdata_q       <= '0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            type_q        <= type_d;
            off_q         <= off_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            err_align_q   <= err_align_d;
            err_timeout_q <= err_timeout_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
        end
    end

    // Stall covers the arrival cycle in IDLE and every REQ cycle.
    always_comb begin
        stall = ((state_q == S_IDLE) && mem_valid) || (state_q == S_REQ);
    end

    assign done        = done_q;
    assign rdata       = rdata_q;
    assign err_align   = err_align_q;
    assign err_timeout = err_timeout_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: table of accesses plus reset/idle-ack sequences.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err_align;
    logic        err_timeout;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    mem_bus_master #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall(stall), .done(done), .rdata(rdata), .err_align(err_align),
        .err_timeout(err_timeout), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          ack_on;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwd;
        logic [31:0] rd;
        logic        ealign;
        logic        etime;
        int          stall_n;
        int          req_n;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc = 0;
        int          stall_n = 0;
        int          req_n = 0;
        logic        seen = 1'b0;
        logic        held = 1'b1;
        logic        req_at_done = 1'b0;
        logic        stall_at_done = 1'b0;
        logic [31:0] c_addr = '0;
        logic [31:0] c_wd = '0;
        logic [3:0]  c_be = '0;
        logic        c_we = 1'b0;
        logic [31:0] d_rd = '0;
        logic        d_ea = 1'b0;
        logic        d_et = 1'b0;
        string       p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_we    = v.we;
        mem_type  = v.typ;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        bus_rdata = v.brd;
        #1;
        while (!seen && cyc < 40) begin
            if (stall) stall_n++;
            if (bus_req) begin
                req_n++;
                if (req_n == 1) begin
                    c_addr = bus_addr; c_wd = bus_wdata; c_be = bus_be; c_we = bus_we;
                end else if (bus_addr !== c_addr || bus_wdata !== c_wd ||
                             bus_be !== c_be || bus_we !== c_we) begin
                    held = 1'b0;
                end
                bus_ack = (v.ack_on == req_n);
            end else begin
                bus_ack = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                d_rd = rdata; d_ea = err_align; d_et = err_timeout;
                req_at_done = bus_req; stall_at_done = stall;
                mem_valid = 1'b0;
            end else begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        chk({p, "_done_seen"}, 32'(seen), 32'd1);
        chk({p, "_stall_cycles"}, 32'(stall_n), 32'(v.stall_n));
        chk({p, "_req_cycles"}, 32'(req_n), 32'(v.req_n));
        chk({p, "_rdata"}, d_rd, v.rd);
        chk({p, "_err_align"}, 32'(d_ea), 32'(v.ealign));
        chk({p, "_err_timeout"}, 32'(d_et), 32'(v.etime));
        chk({p, "_req_at_done"}, 32'(req_at_done), 32'd0);
        chk({p, "_stall_at_done"}, 32'(stall_at_done), 32'd0);
        if (v.req_n > 0) begin
            chk({p, "_bus_addr"}, c_addr, v.baddr);
            chk({p, "_bus_be"}, 32'(c_be), 32'(v.be));
            chk({p, "_bus_wdata"}, c_wd, v.bwd);
            chk({p, "_bus_we"}, 32'(c_we), 32'(v.we));
            chk({p, "_bus_held"}, 32'(held), 32'd1);
        end
        @(negedge clk);
        #1;
        chk({p, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({p, "_stall_after"}, 32'(stall), 32'd0);
    endtask

    initial begin
        //          we    typ     addr          wdata         bus_rdata     ack be       baddr         bwd           rdata         ea    et    st rq
        vecs[0]  = '{1'b1, 3'b000, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,        3, 4'b1111, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 4, 3};
        vecs[1]  = '{1'b0, 3'b011, 32'h0000_1003, 32'h0,        32'h8012_3456, 1, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 2, 1};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h8012_3456, 1, 4'b1000, 32'h0000_1000, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 2, 1};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_1002, 32'h0,        32'h8012_3456, 1, 4'b1100, 32'h0000_1000, 32'h0,        32'hFFFF_8012, 1'b0, 1'b0, 2, 1};
        vecs[4]  = '{1'b1, 3'b001, 32'h0000_1002, 32'h1234_ABCD, 32'h0,        2, 4'b1100, 32'h0000_1000, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0, 3, 2};
        vecs[5]  = '{1'b0, 3'b000, 32'h0000_1002, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_2000, 32'h0,        32'hCAFE_F00D, 1, 4'b0011, 32'h0000_2000, 32'h0,        32'h0000_F00D, 1'b0, 1'b0, 2, 1};
        vecs[7]  = '{1'b0, 3'b100, 32'h0000_2001, 32'h0,        32'hCAFE_F00D, 2, 4'b0010, 32'h0000_2000, 32'h0,        32'h0000_00F0, 1'b0, 1'b0, 3, 2};
        vecs[8]  = '{1'b0, 3'b011, 32'h0000_2002, 32'h0,        32'hCAFE_F00D, 1, 4'b0100, 32'h0000_2000, 32'h0,        32'hFFFF_FFFE, 1'b0, 1'b0, 2, 1};
        vecs[9]  = '{1'b1, 3'b011, 32'h0000_3001, 32'h1234_56A5, 32'h0,        1, 4'b0010, 32'h0000_3000, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0, 2, 1};
        vecs[10] = '{1'b0, 3'b000, 32'h0000_3004, 32'h0,        32'h89AB_CDEF, 1, 4'b1111, 32'h0000_3004, 32'h0,        32'h89AB_CDEF, 1'b0, 1'b0, 2, 1};
        vecs[11] = '{1'b1, 3'b001, 32'h0000_3001, 32'h5555_5555, 32'h0,        1, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
        vecs[12] = '{1'b0, 3'b111, 32'h0000_3008, 32'h0,        32'h0102_0304, 1, 4'b1111, 32'h0000_3008, 32'h0,        32'h0102_0304, 1'b0, 1'b0, 2, 1};
        vecs[13] = '{1'b0, 3'b101, 32'h0000_3002, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1, 0};
        vecs[14] = '{1'b0, 3'b000, 32'h0000_4000, 32'h0,        32'h1111_2222, 0, 4'b1111, 32'h0000_4000, 32'h0,        32'h0,        1'b0, 1'b1, 17, 16};

        reset = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_type = '0;
        mem_addr = '0; mem_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_errs", 32'({err_align, err_timeout}), 32'd0);
        chk("rst_bus_ctl", 32'({bus_req, bus_we, bus_be}), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Reset while a request is outstanding, then a stray ack two cycles later.
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b0; mem_type = 3'b000;
        mem_addr = 32'h0000_5000; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        chk("rsq_req_up", 32'(bus_req), 32'd1);
        reset = 1'b1; mem_valid = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        chk("rsq_req_low", 32'(bus_req), 32'd0);
        chk("rsq_stall_low", 32'(stall), 32'd0);
        chk("rsq_no_done", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        bus_ack = 1'b1;
        @(negedge clk);
        #1;
        bus_ack = 1'b0;
        chk("rsq_late_ack_done", 32'(done), 32'd0);
        chk("rsq_late_ack_rdata", rdata, 32'd0);
        chk("rsq_late_ack_req", 32'(bus_req), 32'd0);
        @(negedge clk);
        #1;
        chk("rsq_late_ack_done2", 32'(done), 32'd0);

        // Load leaves nonzero rdata; an ack while idle must not disturb it.
        run_vec(vecs[10], 15);
        @(negedge clk);
        #1;
        bus_rdata = 32'hAAAA_5555; bus_ack = 1'b1;
        @(negedge clk);
        #1;
        bus_ack = 1'b0;
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_rdata", rdata, 32'h89AB_CDEF);
        chk("idle_ack_req", 32'(bus_req), 32'd0);
        chk("idle_ack_stall", 32'(stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
